// File: rtl/arm_flags_pkg.sv
// rtl/arm_flags_pkg.sv - shared flag indices, mask constants and status state encoding
package arm_flags_pkg;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] MASK_ALL   = 4'b1111;
  localparam logic [3:0] MASK_LOGIC = 4'b1110;

  typedef enum logic {
    SR_NORMAL = 1'b0,
    SR_EXC    = 1'b1
  } sr_state_t;

endpackage

// File: rtl/status_flag_merge.sv
// rtl/status_flag_merge.sv - per-flag select between ALU result and current flags
module status_flag_merge (
  input  logic [3:0] alu_flags,
  input  logic [3:0] mask,
  input  logic [3:0] flags,
  output logic [3:0] merged
);

  assign merged = (alu_flags & mask) | (flags & ~mask);

endmodule

// File: rtl/status_register_unit.sv
// rtl/status_register_unit.sv - {Z,C,N,V} status register with EXE bypass and exception shadow
module status_register_unit
  import arm_flags_pkg::*;
#(
  parameter bit         FWD_EN      = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       freeze,
  input  logic       exe_valid,
  input  logic       exe_s,
  input  logic [3:0] exe_flag_mask,
  input  logic [3:0] alu_flags,
  input  logic       exc_enter,
  input  logic       exc_return,
  output logic [3:0] status_reg,
  output logic [3:0] status_fwd,
  output logic       in_exception,
  output logic       exc_overflow
);

  sr_state_t  state, next_state;
  logic [3:0] shadow, next_shadow, next_flags;
  logic [3:0] merged;
  logic       next_overflow;
  logic       upd;

  status_flag_merge u_merge (
    .alu_flags (alu_flags),
    .mask      (exe_flag_mask),
    .flags     (status_reg),
    .merged    (merged)
  );

  assign upd = exe_valid & exe_s & ~freeze;

  // Bypass ignores freeze: a stalled EXE instruction will still commit these flags.
  assign status_fwd   = (FWD_EN && exe_valid && exe_s) ? merged : status_reg;
  assign in_exception = (state == SR_EXC);

  always_comb begin
    next_state    = state;
    next_flags    = status_reg;
    next_shadow   = shadow;
    next_overflow = exc_overflow;
    if (!freeze) begin
      if (state == SR_EXC && exc_return) begin
        next_flags = shadow;
        next_state = SR_NORMAL;
      end else begin
        if (upd) begin
          next_flags = merged;
        end
        if (exc_enter) begin
          if (state == SR_NORMAL) begin
            next_shadow = upd ? merged : status_reg;
            next_state  = SR_EXC;
          end else begin
            next_overflow = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= SR_NORMAL;
      status_reg   <= RESET_FLAGS;
      shadow       <= RESET_FLAGS;
      exc_overflow <= 1'b0;
    end else begin
      state        <= next_state;
      status_reg   <= next_flags;
      shadow       <= next_shadow;
      exc_overflow <= next_overflow;
    end
  end

endmodule

// File: tb/tb_status_register_unit.sv
// tb/tb_status_register_unit.sv - table-driven scoreboard bench for status_register_unit
module tb_status_register_unit;

  logic       clk = 1'b0;
  logic       rst_n, freeze, exe_valid, exe_s, exc_enter, exc_return;
  logic [3:0] exe_flag_mask, alu_flags;
  logic [3:0] status_reg, status_fwd, status_reg_b, status_fwd_b;
  logic       in_exception, exc_overflow, in_exception_b, exc_overflow_b;

  always #5 clk = ~clk;

  status_register_unit #(.FWD_EN(1'b1), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .exe_valid(exe_valid), .exe_s(exe_s),
    .exe_flag_mask(exe_flag_mask), .alu_flags(alu_flags), .exc_enter(exc_enter),
    .exc_return(exc_return), .status_reg(status_reg), .status_fwd(status_fwd),
    .in_exception(in_exception), .exc_overflow(exc_overflow)
  );

  status_register_unit #(.FWD_EN(1'b0), .RESET_FLAGS(4'b0000)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .exe_valid(exe_valid), .exe_s(exe_s),
    .exe_flag_mask(exe_flag_mask), .alu_flags(alu_flags), .exc_enter(exc_enter),
    .exc_return(exc_return), .status_reg(status_reg_b), .status_fwd(status_fwd_b),
    .in_exception(in_exception_b), .exc_overflow(exc_overflow_b)
  );

  typedef struct packed {
    logic       rst;
    logic       frz;
    logic       v;
    logic       s;
    logic [3:0] mask;
    logic [3:0] alu;
    logic       en;
    logic       ret;
    logic [3:0] fwd;
    logic [3:0] reg_q;
    logic       inx;
    logic       ovf;
  } vec_t;

  typedef struct packed {
    logic [3:0] reg_q;
    logic       inx;
    logic       ovf;
  } exp_t;

  vec_t       tbl[$];
  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [3:0] prev_reg;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n         = t.rst;
    freeze        = t.frz;
    exe_valid     = t.v;
    exe_s         = t.s;
    exe_flag_mask = t.mask;
    alu_flags     = t.alu;
    exc_enter     = t.en;
    exc_return    = t.ret;
  endtask

  initial begin
    exp_t e;
    // rst frz v s mask alu en ret | fwd reg inx ovf
    tbl.push_back('{1,0,1,1,4'hF,4'hF,0,0, 4'hF,4'hF,0,0}); // reset release commits
    tbl.push_back('{1,0,1,1,4'hF,4'h1,0,0, 4'h1,4'h1,0,0});
    tbl.push_back('{1,0,1,1,4'hE,4'hA,0,0, 4'hB,4'hB,0,0}); // logic mask keeps V
    tbl.push_back('{1,0,1,0,4'hF,4'h0,0,0, 4'hB,4'hB,0,0}); // S clear
    tbl.push_back('{1,0,1,1,4'hF,4'h4,0,0, 4'h4,4'h4,0,0});
    tbl.push_back('{1,1,1,1,4'hF,4'h9,1,0, 4'h9,4'h4,0,0}); // freeze x3
    tbl.push_back('{1,1,1,1,4'hF,4'h9,1,0, 4'h9,4'h4,0,0});
    tbl.push_back('{1,1,1,1,4'hF,4'h9,1,0, 4'h9,4'h4,0,0});
    tbl.push_back('{1,0,1,1,4'hF,4'h9,0,0, 4'h9,4'h9,0,0});
    tbl.push_back('{1,0,1,1,4'hF,4'h2,0,0, 4'h2,4'h2,0,0});
    tbl.push_back('{1,0,1,1,4'hF,4'h8,1,0, 4'h8,4'h8,1,0}); // enter, shadow=8
    tbl.push_back('{1,0,1,1,4'hF,4'h5,0,0, 4'h5,4'h5,1,0});
    tbl.push_back('{1,0,1,1,4'hF,4'h3,1,0, 4'h3,4'h3,1,1}); // nested enter
    tbl.push_back('{1,0,1,1,4'hF,4'hF,0,1, 4'hF,4'h8,0,1}); // return restores 8
    tbl.push_back('{1,0,1,1,4'h6,4'h6,0,1, 4'hE,4'hE,0,1}); // spurious return
    tbl.push_back('{1,0,0,0,4'h0,4'h0,0,1, 4'hE,4'hE,0,1});
    tbl.push_back('{1,0,1,1,4'h0,4'hF,0,0, 4'hE,4'hE,0,1}); // empty mask no-op
    tbl.push_back('{1,0,1,1,4'hE,4'h0,0,0, 4'h0,4'h0,0,1});
    tbl.push_back('{1,0,0,1,4'hF,4'h7,0,0, 4'h0,4'h0,0,1}); // not valid
    tbl.push_back('{1,0,0,0,4'hF,4'h0,1,0, 4'h0,4'h0,1,1}); // enter, shadow=0
    tbl.push_back('{1,0,1,1,4'hF,4'hA,1,1, 4'hA,4'h0,0,1}); // return beats enter and upd
    tbl.push_back('{1,0,1,1,4'hF,4'h5,1,0, 4'h5,4'h5,1,1});
    tbl.push_back('{0,0,1,1,4'hF,4'hF,0,0, 4'hF,4'h0,0,0}); // reset mid-exception
    tbl.push_back('{1,0,0,0,4'h0,4'h0,0,1, 4'h0,4'h0,0,0}); // state was cleared

    // Reset held two cycles with a live flag-setting instruction
    @(negedge clk);
    drive('{0,0,1,1,4'hF,4'hF,0,0, 4'h0,4'h0,0,0});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset status_reg", -1, status_reg, 4'h0);
      chk("reset in_exception", -1, {3'b0, in_exception}, 4'h0);
      chk("reset exc_overflow", -1, {3'b0, exc_overflow}, 4'h0);
    end
    prev_reg = 4'h0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk("status_fwd", i, status_fwd, tbl[i].fwd);
      chk("status_fwd nofwd", i, status_fwd_b, prev_reg);
      sb.push_back('{tbl[i].reg_q, tbl[i].inx, tbl[i].ovf});
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL scoreboard row %0d: got empty queue expected entry", i);
      end else begin
        e = sb.pop_front();
        chk("status_reg", i, status_reg, e.reg_q);
        chk("in_exception", i, {3'b0, in_exception}, {3'b0, e.inx});
        chk("exc_overflow", i, {3'b0, exc_overflow}, {3'b0, e.ovf});
        chk("status_reg nofwd", i, status_reg_b, e.reg_q);
        chk("in_exception nofwd", i, {3'b0, in_exception_b}, {3'b0, e.inx});
        prev_reg = e.reg_q;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/status_register_unit.md
Name: status_register_unit

Overview:
- Holds the architectural condition flags {Z,C,N,V} and commits ALU flag results from the EXE stage when the S bit is set.
- Drives the 4-bit status bus consumed by the ID-stage condition checker. Bit order is [3]=Z, [2]=C, [1]=N, [0]=V.
- Provides a combinational bypass so a conditional instruction in ID sees flags being written in the same cycle.
- Holds a single-level shadow copy of the flags for exception entry and return.

Parameters:
- FWD_EN, 1, 1 enables the EXE→status_fwd bypass; 0 makes status_fwd equal status_reg.
- RESET_FLAGS, 4'b0000, value loaded into status_reg and shadow on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- freeze  in  1  pipeline stall; blocks every state update.
- exe_valid  in  1  EXE stage holds a live instruction.
- exe_s  in  1  S bit of the EXE instruction (flag-setting).
- exe_flag_mask  in  4  per-flag write enable {Z,C,N,V}; 1 = take the ALU value.
- alu_flags  in  4  flags produced by the ALU {Z,C,N,V}.
- exc_enter  in  1  exception entry pulse; save flags to shadow.
- exc_return  in  1  exception return pulse; restore flags from shadow.
- status_reg  out  4  registered architectural flags.
- status_fwd  out  4  flags for the condition checker, with the EXE bypass applied.
- in_exception  out  1  high while the shadow holds saved flags.
- exc_overflow  out  1  sticky error flag for a nested exc_enter.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low via rst_n. Polarity and synchronicity are fixed.
- Reset values: status_reg=RESET_FLAGS, shadow=RESET_FLAGS, state=NORMAL, in_exception=0, exc_overflow=0. Reset overrides every other input in the same edge.
- Merge rule: merged = (alu_flags & exe_flag_mask) | (status_reg & ~exe_flag_mask). This is bitwise with no arithmetic.
  - Full ALU ops use mask 4'b1111.
  - Logic ops use 4'b1110 (V preserved).
- Commit condition: upd = exe_valid & exe_s & ~freeze. On upd, status_reg <= merged at the next edge, so latency is 1 cycle.
- Bypass: status_fwd = (FWD_EN & exe_valid & exe_s) ? merged : status_reg.
  - Purely combinational, 0-cycle.
  - Ignores freeze, because a frozen EXE instruction still commits later.
  - Does not reflect a pending exc_return.
- State machine: NORMAL, EXC. in_exception = (state==EXC).
- When freeze=1, nothing changes: flags, shadow, state and exc_overflow all hold, and exc_enter/exc_return are ignored.
- Priority when freeze=0: exc_return > exc_enter > upd.
- NORMAL, exc_enter=1:
  - shadow <= upd ? merged : status_reg, so the completing instruction's flags are saved.
  - status_reg still takes the upd result.
  - state <= EXC.
- NORMAL, exc_return=1: ignored as a spurious return. upd proceeds normally and the state is unchanged.
- EXC, exc_return=1:
  - status_reg <= shadow and state <= NORMAL.
  - A simultaneous upd is discarded.
  - A simultaneous exc_enter is ignored.
- EXC, exc_enter=1 (nesting is unsupported):
  - exc_overflow <= 1 (sticky until reset).
  - shadow is not overwritten; upd proceeds; state stays EXC.
- EXC with no pulse: upd updates status_reg normally; shadow holds.
- Reset mid-exception: shadow and state are cleared; the saved flags are lost.
- exe_flag_mask=0 with exe_s=1: merged=status_reg, so this is a legal no-op.

Decomposition:
- Shared package (arm_flags_pkg):
  - Flag index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - Mask constants MASK_ALL=4'b1111, MASK_LOGIC=4'b1110.
  - 1-bit state encoding SR_NORMAL=0, SR_EXC=1.
- Sub-module status_flag_merge (combinational): inputs alu_flags, mask, current flags; output merged. It is instantiated once, and its output is shared by the commit path, the bypass and the shadow capture.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with alu_flags=4'hF, exe_valid=1, exe_s=1 -> status_reg=4'b0000, in_exception=0, exc_overflow=0. Release; next edge -> status_reg=4'b1111.
- Bypass and mask: status_reg=4'b0001, EXE drives alu_flags=4'b1010 with mask=4'b1110 -> status_fwd=4'b1011 in the same cycle; status_reg=4'b1011 after 1 edge. Repeat with exe_s=0 -> status_fwd=status_reg=4'b1011, no change.
- Freeze: status_reg=4'b0100, freeze=1, upd and exc_enter asserted for 3 cycles -> status_reg=4'b0100, state NORMAL, status_fwd shows the merged value. Drop freeze -> commit on the next edge.
- Exception round trip: status_reg=4'b0010, exc_enter together with upd(alu_flags=4'b1000, mask=4'hF) -> shadow=4'b1000, in_exception=1. Handler upd 4'b0101 -> status_reg=4'b0101. exc_return together with upd 4'b1111 -> status_reg=4'b1000, in_exception=0.
- Nested and spurious: in EXC, exc_enter -> exc_overflow=1 with shadow unchanged; it stays 1 after the return until rst_n=0. In NORMAL, exc_return -> no state or flag change.
- FWD_EN=0 build: repeat the bypass scenario -> status_fwd equals status_reg every cycle.
